// File: rtl/exo_qspi_pkg.sv
// exo_qspi_pkg: shared states, command opcodes and size/byte-order helpers
package exo_qspi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_e;
  typedef enum logic [1:0] {SZ_1B = 2'd0, SZ_2B = 2'd1, SZ_4B = 2'd3} size_e;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  function automatic size_e norm_size(input logic [1:0] s);
    return s == 2'd2 ? SZ_4B : size_e'(s);
  endfunction
  // Bytes leave MSB-first in ascending address order, so byte 0 goes on top.
  function automatic logic [31:0] order_wdata(input logic [31:0] wd);
    return {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
  endfunction
  // The first received byte sits highest in the shift register; move it to [7:0].
  function automatic logic [31:0] order_rdata(input logic [31:0] rd, input size_e sz);
    return sz == SZ_1B ? {24'd0, rd[7:0]} :
           sz == SZ_2B ? {16'd0, rd[7:0], rd[15:8]} :
                         {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
  endfunction
endpackage

// File: rtl/exo_qspi_sckgen.sv
// exo_qspi_sckgen: mode-0 serial clock with a strobe on the clk edge that ends each high phase
module exo_qspi_sckgen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic fall_o
);
  localparam int CW = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
  logic [CW-1:0] cnt_q;
  logic sck_q, rise;
  assign rise   = en_i && cnt_q == CW'(CLK_DIV - 1);
  assign fall_o = en_i && cnt_q == CW'(2 * CLK_DIV - 1);
  assign sck_o  = sck_q;
  // Count CLK_DIV low clocks then CLK_DIV high clocks; idle low while disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= fall_o ? '0 : cnt_q + CW'(1);
      sck_q <= rise ? 1'b1 : fall_o ? 1'b0 : sck_q;
    end
  end
endmodule

// File: rtl/exo_qspi_mem_ctrl.sv
// exo_qspi_mem_ctrl: multi-chip-select single/quad SPI memory controller
module exo_qspi_mem_ctrl
  import exo_qspi_pkg::*;
#(
  parameter int NUM_CS = 2,
  parameter int ADDR_W = 24,
  parameter logic [NUM_CS-1:0] QUAD_MASK = 2'b01,
  parameter int CLK_DIV = 1,
  parameter int DUMMY_CYC = 4,
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [CSW-1:0]    cs_sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic [NUM_CS-1:0] mem_cs_on,
  output logic              mem_sck_o,
  output logic [3:0]        mem_sd_o,
  output logic [3:0]        mem_sd_oen_o,
  input  logic [3:0]        mem_sd_i
);
  localparam int TW = ADDR_W + 40;
  localparam int LW = 16;
  state_e state_q, state_d;
  size_e sz_q, sz_d;
  logic [TW-1:0] tx_q, tx_d;
  logic [31:0] rd_q, rd_d, rdata_q, rdata_d;
  logic [LW-1:0] left_q, left_d, addr_len, data_len;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [3:0] sd_q, sd_d, oen_q, oen_d;
  logic quad_q, quad_d, we_q, we_d, ack_q, ack_d, ready_q, ready_d;
  logic en, fall;
  logic [2:0] nbytes;
  assign en       = state_q inside {CMD, ADDR, DUMMY, DATA};
  assign nbytes   = {1'b0, sz_q} + 3'd1;
  assign addr_len = quad_q ? LW'(ADDR_W / 4) : LW'(ADDR_W);
  assign data_len = quad_q ? LW'({nbytes, 1'b0}) : LW'({nbytes, 3'b000});
  assign ready_o      = ready_q;
  assign ack_o        = ack_q;
  assign rdata_o      = rdata_q;
  assign mem_cs_on    = cs_n_q;
  assign mem_sd_o     = sd_q;
  assign mem_sd_oen_o = oen_q;
  exo_qspi_sckgen #(.CLK_DIV(CLK_DIV)) u_sckgen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en),
    .sck_o (mem_sck_o),
    .fall_o(fall)
  );
  // Next-state: accept, advance one SCK per strobe, and precompute the pad outputs.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    left_d  = left_q;
    sz_d    = sz_q;
    quad_d  = quad_q;
    we_d    = we_q;
    cs_n_d  = cs_n_q;
    ack_d   = 1'b0;
    if (state_q == IDLE && req_i) begin
      if (32'(cs_sel_i) >= NUM_CS) begin
        state_d = DONE;
        ack_d   = 1'b1;
        rdata_d = '0;
      end else begin
        state_d = CMD;
        quad_d  = QUAD_MASK[cs_sel_i];
        we_d    = we_i;
        sz_d    = norm_size(size_i);
        left_d  = LW'(8);
        rd_d    = '0;
        cs_n_d  = ~(NUM_CS'(1) << cs_sel_i);
        tx_d    = {QUAD_MASK[cs_sel_i] ? (we_i ? CMD_QWRITE : CMD_QREAD) : (we_i ? CMD_WRITE : CMD_READ),
                   addr_i, we_i ? order_wdata(wdata_i) : 32'd0};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (fall) begin
      tx_d   = state_q == DUMMY ? tx_q : (state_q == CMD || !quad_q) ? tx_q << 1 : tx_q << 4;
      rd_d   = (state_q == DATA && !we_q) ? (quad_q ? {rd_q[27:0], mem_sd_i} : {rd_q[30:0], mem_sd_i[1]}) : rd_q;
      left_d = left_q - LW'(1);
      if (left_q == LW'(1)) begin
        case (state_q)
          CMD: begin
            state_d = ADDR;
            left_d  = addr_len;
          end
          ADDR: begin
            state_d = (quad_q && !we_q && DUMMY_CYC > 0) ? DUMMY : DATA;
            left_d  = (quad_q && !we_q && DUMMY_CYC > 0) ? LW'(DUMMY_CYC) : data_len;
          end
          DUMMY: begin
            state_d = DATA;
            left_d  = data_len;
          end
          DATA: begin
            state_d = DONE;
            cs_n_d  = '1;
            ack_d   = 1'b1;
            rdata_d = we_q ? rdata_q : order_rdata(rd_d, sz_q);
          end
          default: ;
        endcase
      end
    end
    oen_d   = state_d == CMD  ? 4'b0001 :
              state_d == ADDR ? (quad_d ? 4'b1111 : 4'b0001) :
              state_d == DATA ? (!quad_d ? 4'b0001 : we_d ? 4'b1111 : 4'b0000) : 4'b0000;
    sd_d    = (quad_d && state_d != CMD ? tx_d[TW-1 -: 4] : {3'b000, tx_d[TW-1]}) & oen_d;
    ready_d = state_d == IDLE;
  end
  // Register FSM state and every pad/handshake output; reset aborts any transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sz_q    <= SZ_1B;
      tx_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      left_q  <= '0;
      cs_n_q  <= '1;
      sd_q    <= '0;
      oen_q   <= '0;
      quad_q  <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sz_q    <= sz_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      left_q  <= left_d;
      cs_n_q  <= cs_n_d;
      sd_q    <= sd_d;
      oen_q   <= oen_d;
      quad_q  <= quad_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
    end
  end
endmodule
